pri_decoder_hold: RTL

//  Reverse end of the priority-encoder path: accepts a binary code plus valid flag
//  (the encoder's y/v pair) over a valid/ready handshake and drives a registered
//  one-hot line select. Each select is held for HOLD cycles, then released.

---
 rtl/pri_codec_pkg.sv | 25 ++
 rtl/pri_decoder_hold_counter.sv | 38 +++
 rtl/pri_decoder_hold.sv | 109 ++++++++++
 3 files changed

// File: rtl/pri_codec_pkg.sv
// Shared definitions for both ends of the priority codec path: state encoding,
// code-width limits and the code -> one-hot mapping (bit i <-> code i).
package pri_codec_pkg;

   // Widest code either end supports; the one-hot helper is sized for it.
   localparam int MAX_CODE_W = 8;
   localparam int MAX_LINES  = 1 << MAX_CODE_W;

   // Width of the hold-cycle down counter (HOLD is limited to 1..255).
   localparam int HOLD_CNT_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Code -> one-hot select. Callers truncate the result to 2**CODE_W lines.
   function automatic logic [MAX_LINES-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
      logic [MAX_LINES-1:0] sel;
      sel       = '0;
      sel[code] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/pri_decoder_hold_counter.sv
// Hold-cycle down counter: parallel load, decrement that stops at zero, zero flag.
module hold_counter
   import pri_codec_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [HOLD_CNT_W-1:0] load_val,
   input  logic                  dec,
   output logic [HOLD_CNT_W-1:0] cnt,
   output logic                  zero
);

   logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

   // Load wins over decrement; decrement never wraps below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - HOLD_CNT_W'(1);
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pri_decoder_hold.sv
// Binary code -> registered one-hot select, each select held for HOLD cycles.
// Valid/ready input; a new code is taken only when idle or on the last hold cycle,
// so back-to-back codes produce selects with no gap cycle between them.
module pri_decoder_hold
   import pri_codec_pkg::*;
#(
   parameter int CODE_W = 2,
   parameter int HOLD   = 3,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [CODE_W-1:0]      in_code,
   output logic                   in_ready,
   output logic [(1<<CODE_W)-1:0] out_onehot,
   output logic                   out_valid,
   output logic                   busy,
   output logic [CNT_W-1:0]       dec_count
);

   localparam int NLINES = 1 << CODE_W;

   if (HOLD < 1 || HOLD > 255 || CODE_W < 1 || CODE_W > MAX_CODE_W) begin : g_bad_param
      $error("pri_decoder_hold: illegal parameters CODE_W=%0d HOLD=%0d", CODE_W, HOLD);
   end

   // Counter reload value: the accept cycle's successor is the first hold cycle.
   localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD - 1);

   state_e                state_q, state_d;
   logic [NLINES-1:0]     onehot_q, onehot_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [NLINES-1:0]     dec_sel;
   logic                  accept;
   logic                  cnt_load, cnt_dec, cnt_zero;
   logic [HOLD_CNT_W-1:0] hold_cnt;

   hold_counter u_hold_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (HOLD_LOAD),
      .dec      (cnt_dec),
      .cnt      (hold_cnt),
      .zero     (cnt_zero)
   );

   // Ready depends only on state and counter, never on in_valid.
   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && cnt_zero);
   assign accept   = in_valid && in_ready;
   assign dec_sel  = NLINES'(onehot(MAX_CODE_W'(in_code)));

   // Next-state, select register and accept counter.
   always_comb begin
      state_d  = state_q;
      onehot_d = onehot_q;
      count_d  = count_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_HOLD;
               onehot_d = dec_sel;
               count_d  = count_q + CNT_W'(1);
               cnt_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!cnt_zero) begin
               // Still holding: input is ignored even if valid.
               cnt_dec = 1'b1;
            end else if (accept) begin
               // Last hold cycle overlaps with the next accept: no gap.
               onehot_d = dec_sel;
               count_d  = count_q + CNT_W'(1);
               cnt_load = 1'b1;
            end else begin
               state_d  = ST_IDLE;
               onehot_d = '0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            onehot_d = '0;
         end
      endcase
   end

   // State, select and counter registers; reset clears outputs without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         onehot_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
         count_q  <= count_d;
      end
   end

   assign out_onehot = onehot_q;
   assign out_valid  = (state_q == ST_HOLD);
   assign busy       = (state_q == ST_HOLD);
   assign dec_count  = count_q;

endmodule
